// File: rtl/uart_rom_loader.sv
// ---------------------------------------------------------------------------
// uart_rom_loader: receives a length-prefixed 8N1 byte stream and feeds it
// word-by-word to a SoC ROM loader. Optional trailing checksum: define
// UART_ROM_LOADER_CHECKSUM_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 218,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  rom_loader_reset,
  output logic                  rom_loader_load,
  output logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_load_received,
  input  logic                  rom_loader_ack,
  output logic                  busy,
  output logic                  done_loading,
  output logic                  error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LEN_HI   = 4'd1;
  localparam logic [3:0] LEN_LO   = 4'd2;
  localparam logic [3:0] WORD_HI  = 4'd3;
  localparam logic [3:0] WORD_LO  = 4'd4;
  localparam logic [3:0] LOAD     = 4'd5;
  localparam logic [3:0] WAIT_ACK = 4'd6;
  localparam logic [3:0] DONE     = 4'd8;
  localparam logic [3:0] ERROR    = 4'd9;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  localparam logic [3:0] CHECK    = 4'd7;
  localparam logic [3:0] TAIL     = CHECK;
`else
  localparam logic [3:0] TAIL     = DONE;
`endif

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_valid, rx_ferr;
  logic             rx_start_edge;

  assign rx_start_edge = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_start_edge) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_valid <= rx_sync;
            rx_ferr  <= !rx_sync;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [3:0]            state;
  logic                  buf_full;
  logic [7:0]            buf_data;
  logic [15:0]           remaining;
  logic [7:0]            len_hi, word_hi;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  consume, active, overrun;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  always_comb begin
    consume = 1'b0;
    case (state)
      LEN_HI, LEN_LO, WORD_HI, WORD_LO: consume = buf_full;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      CHECK: consume = buf_full;
`endif
      default: consume = 1'b0;
    endcase
  end

  assign active  = (state != DONE) && (state != ERROR);
  assign overrun = rx_valid && buf_full && !consume;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      remaining <= '0;
      len_hi    <= '0;
      word_hi   <= '0;
      data_q    <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // Single-entry byte buffer decouples the receiver from the SoC handshake
      if (active && rx_valid) begin
        buf_full <= 1'b1;
        buf_data <= rx_shift;
      end else if (consume) begin
        buf_full <= 1'b0;
      end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      if (consume && state != CHECK) csum <= csum + buf_data;
`endif
      if (active && (rx_ferr || overrun)) begin
        state <= ERROR;
      end else begin
        case (state)
          IDLE:     if (rx_start_edge) state <= LEN_HI;
          LEN_HI: begin
            if (consume) begin
              len_hi <= buf_data;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (consume) begin
              remaining <= {len_hi, buf_data};
              state     <= ({len_hi, buf_data} == 16'd0) ? TAIL : WORD_HI;
            end
          end
          WORD_HI: begin
            if (consume) begin
              word_hi <= buf_data;
              state   <= WORD_LO;
            end
          end
          WORD_LO: begin
            if (consume) begin
              data_q <= DATA_WIDTH'({word_hi, buf_data});
              state  <= LOAD;
            end
          end
          LOAD:     if (rom_loader_load_received) state <= WAIT_ACK;
          WAIT_ACK: begin
            if (rom_loader_ack) begin
              remaining <= remaining - 16'd1;
              state     <= (remaining == 16'd1) ? TAIL : WORD_HI;
            end
          end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
          CHECK: if (consume) state <= (buf_data == csum) ? DONE : ERROR;
`endif
          DONE, ERROR: state <= state;
          default:     state <= ERROR;
        endcase
      end
    end
  end

  assign rom_loader_load  = (state == LOAD);
  assign rom_loader_data  = data_q;
  assign busy             = active && (state != IDLE) && (state != LEN_HI);
  assign rom_loader_reset = busy;
  assign done_loading     = (state == DONE);
  assign error            = (state == ERROR);

endmodule

`default_nettype wire

// File: doc/uart_rom_loader.md
UART_ROM_LOADER -- requirements
Module: uart_rom_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 218, clock cycles per UART bit (115200 baud at 25.125 MHz).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one ROM instruction word.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port rom_loader_reset  output  1  held high while a load is in progress.
REQ-007 SHALL have port rom_loader_load  output  1  word-valid strobe to the SoC loader.
REQ-008 SHALL have port rom_loader_data  output  DATA_WIDTH  instruction word.
REQ-009 SHALL have port rom_loader_load_received  input  1  SoC has latched the current word.
REQ-010 SHALL have port rom_loader_ack  input  1  SoC has finished writing the current word.
REQ-011 SHALL have port busy  output  1  high from first header byte until DONE or ERROR.
REQ-012 SHALL have port done_loading  output  1  level, high in DONE.
REQ-013 SHALL have port error  output  1  level, high in ERROR.

Function
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer before use.
REQ-015 SHALL detect a start bit on a synchronized falling edge, re-check low at CLKS_PER_BIT/2, sample each data bit LSB-first at bit centre.
REQ-016 SHALL reject a byte whose stop bit samples low (framing error) and enter ERROR.
REQ-017 SHALL treat the stream as: count high byte, count low byte, then count words, each high byte first.
REQ-018 SHALL sequence states IDLE -> LEN_HI -> LEN_LO -> WORD_HI -> WORD_LO -> LOAD -> WAIT_ACK -> WORD_HI ... -> DONE.
REQ-019 SHALL assert rom_loader_reset and busy on receipt of the count high byte; deassert both on entering DONE or ERROR.
REQ-020 SHALL in LOAD drive rom_loader_load high with rom_loader_data stable until the cycle rom_loader_load_received is sampled high, then drop load the next cycle.
REQ-021 SHALL in WAIT_ACK hold load low and advance only when rom_loader_ack is sampled high.
REQ-022 SHALL decrement a 16-bit remaining-word counter per acknowledged word; counter reaching 0 enters DONE.
REQ-023 SHALL enter DONE immediately after LEN_LO when count = 0, issuing no load strobes.
REQ-024 SHALL buffer one received byte while in LOAD/WAIT_ACK; a second byte arriving while the buffer is full SHALL enter ERROR (overrun).
REQ-025 SHALL remain in DONE or ERROR, ignoring uart_rx, until reset.
REQ-026 SHALL keep rom_loader_load low in every state except LOAD.

Reset
REQ-027 SHALL on reset, asynchronously, force state IDLE, receiver idle, buffer empty, counter 0.
REQ-028 SHALL drive all outputs 0 during and immediately after reset, rom_loader_data = 0.
REQ-029 SHALL abandon any in-progress transfer when reset asserts mid-load, with no further strobes after release until a new header arrives.

Configuration
REQ-030 SHALL, with UART_ROM_LOADER_CHECKSUM_EN defined, expect one trailing byte equal to the mod-256 sum of all preceding stream bytes (count bytes included); state CHECK after the last ack; match -> DONE, mismatch -> ERROR.
REQ-031 SHALL, without UART_ROM_LOADER_CHECKSUM_EN, omit CHECK and the accumulator, entering DONE after the last ack.

Verification
REQ-032 SHALL cover: bytes 00 02 12 34 AB CD, SoC acks after 3 cycles -> two strobes with data 16'h1234 then 16'hABCD, done_loading=1, error=0.
REQ-033 SHALL cover: bytes 00 00 -> zero strobes, done_loading=1 one cycle after LEN_LO byte completes.
REQ-034 SHALL cover: byte with stop bit forced low -> error=1, rom_loader_reset=0, no strobe.
REQ-035 SHALL cover: load_received held low 1000 cycles while 2 further bytes arrive -> error=1 (overrun), load dropped.
REQ-036 SHALL cover: reset asserted during WAIT_ACK of word 1 of 3 -> all outputs 0 within same cycle, no strobe until new header.
REQ-037 SHALL cover, CHECKSUM_EN: 00 01 12 34 47 -> done_loading=1; trailing 48 -> error=1.
